// File: rtl/aes_pkg.sv
// Shared AES datapath types, the MixColumns FSM encoding and the GF(2^8) doubling helper.
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  col_t;
    typedef logic [7:0]   byte_t;

    localparam byte_t AES_POLY = 8'h1B;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mc_state_e;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic byte_t xtime(input byte_t x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational AES MixColumns on one 32-bit column; row 0 is the most significant byte.
module mix_single_column
    import aes_pkg::*;
(
    input  col_t col_i,
    output col_t col_o
);

    byte_t a0, a1, a2, a3;
    byte_t x0, x1, x2, x3;

    assign {a0, a1, a2, a3} = col_i;

    assign x0 = xtime(a0);
    assign x1 = xtime(a1);
    assign x2 = xtime(a2);
    assign x3 = xtime(a3);

    // 3a = xtime(a) ^ a
    assign col_o[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
    assign col_o[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
    assign col_o[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
    assign col_o[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: loads one state, mixes COLS_PER_CYCLE columns per clock, then
// holds the result until accepted. A per-block bypass skips the mix for the final round.
module mix_columns_iter
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [2:0] ColStep = 3'(COLS_PER_CYCLE);

    mc_state_e   state_q, state_d;
    logic [1:0]  col_cnt_q, col_cnt_d;
    state_t      work_q, work_d;
    logic        bypass_q, bypass_d;
    logic [2:0]  cnt_sum;

    col_t work_cols [4];
    col_t mix_in    [COLS_PER_CYCLE];
    col_t mix_out   [COLS_PER_CYCLE];

    for (genvar i = 0; i < 4; i++) begin : g_cols
        assign work_cols[i] = work_q[127 - 32*i -: 32];
    end

    // Mixer g always serves column col_cnt + g; the counter wraps mod 4.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
        logic [1:0] rd_idx;
        assign rd_idx    = col_cnt_q + 2'(g);
        assign mix_in[g] = work_cols[rd_idx];

        mix_single_column u_mix (
            .col_i (mix_in[g]),
            .col_o (mix_out[g])
        );
    end

    always_comb begin
        logic [1:0] wr_idx;
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        work_d    = work_q;
        bypass_d  = bypass_q;
        wr_idx    = 2'd0;
        cnt_sum   = {1'b0, col_cnt_q} + ColStep;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d    = in_state;
                    bypass_d  = in_bypass;
                    col_cnt_d = 2'd0;
                    state_d   = in_bypass ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (!bypass_q) begin
                    for (int g = 0; g < int'(COLS_PER_CYCLE); g++) begin
                        wr_idx = col_cnt_q + 2'(g);
                        work_d[(3 - int'(wr_idx))*32 +: 32] = mix_out[g];
                    end
                end
                col_cnt_d = cnt_sum[1:0];
                if (cnt_sum == 3'd4) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            col_cnt_q <= 2'd0;
            work_q    <= '0;
            bypass_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            work_q    <= work_d;
            bypass_q  <= bypass_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_state = work_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed bench for mix_columns_iter at COLS_PER_CYCLE = 1, 2 and 4 against a GF(2^8) model.
module tb_mix_columns_iter;

    logic         clk;
    logic         rst_n;
    logic [2:0]   in_valid;
    logic [2:0]   in_ready;
    logic [127:0] in_state;
    logic         in_bypass;
    logic [2:0]   out_valid;
    logic [2:0]   out_ready;
    logic [127:0] out_state [3];

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] exp_state [3];
    logic [2:0]   exp_have;

    localparam logic [127:0] VecSingle = {4{32'hdb135345}};
    localparam logic [127:0] ExpSingle = {4{32'h8e4da1bc}};
    localparam logic [127:0] VecFips   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] ExpFips   = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] VecFixed  = 128'h01010101_c6c6c6c6_d4d4d4d5_2d26314c;
    localparam logic [127:0] ExpFixed  = 128'h01010101_c6c6c6c6_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] VecByp    = 128'h00112233445566778899aabbccddeeff;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int unsigned Cpc = (k == 0) ? 1 : (k == 1) ? 2 : 4;
        mix_columns_iter #(.COLS_PER_CYCLE(Cpc)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[k]),
            .in_ready  (in_ready[k]),
            .in_state  (in_state),
            .in_bypass (in_bypass),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .out_state (out_state[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // General GF(2^8) product: shift-and-add, then reduce by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h11B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic byp);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] r;
        coef = '{8'd2, 8'd3, 8'd1, 8'd1};
        if (byp) return s;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc ^= gmul(coef[(j - row + 4) % 4], s[(15 - 4*c - j)*8 +: 8]);
                r[(15 - 4*c - row)*8 +: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare process: scoreboard of the one block in flight per instance.
    initial begin
        exp_have = 3'b000;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!rst_n) begin
                    exp_have[k] = 1'b0;
                    check("reset_out_valid", 128'(out_valid[k]), 128'd0);
                    check("reset_in_ready", 128'(in_ready[k]), 128'd1);
                    check("reset_out_state", out_state[k], 128'd0);
                end else begin
                    check("ready_valid_exclusive", 128'(in_ready[k] & out_valid[k]), 128'd0);
                    if (out_valid[k]) begin
                        if (!exp_have[k]) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL spurious_out_valid: inst %0d got 1 required 0", k);
                        end else begin
                            check("scoreboard_out_state", out_state[k], exp_state[k]);
                        end
                        if (out_ready[k]) exp_have[k] = 1'b0;
                    end
                    if (in_valid[k] && in_ready[k]) begin
                        exp_state[k] = model(in_state, in_bypass);
                        exp_have[k]  = 1'b1;
                    end
                end
            end
        end
    end

    task automatic run_block(input int k, input logic [127:0] st, input logic byp,
                             input int exp_lat, input logic [127:0] exp_out, input string name);
        int lat;
        @(posedge clk); #2;
        check({name, "_in_ready"}, 128'(in_ready[k]), 128'd1);
        in_state    = st;
        in_bypass   = byp;
        in_valid[k] = 1'b1;
        @(posedge clk); #2;
        in_valid[k] = 1'b0;
        in_state    = ~st;
        in_bypass   = ~byp;
        lat = 1;
        while (!out_valid[k] && lat < 20) begin
            check({name, "_busy_in_ready"}, 128'(in_ready[k]), 128'd0);
            @(posedge clk); #2;
            lat++;
        end
        check({name, "_latency"}, 128'(lat), 128'(exp_lat));
        check({name, "_out_state"}, out_state[k], exp_out);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 3'b000;
        out_ready = 3'b111;
        in_state  = '0;
        in_bypass = 1'b0;

        #1;
        check("init_in_ready", 128'(in_ready), 128'h7);
        check("init_out_valid", 128'(out_valid), 128'h0);
        check("init_out_state", out_state[0], 128'd0);

        check("model_single", model(VecSingle, 1'b0), ExpSingle);
        check("model_fips", model(VecFips, 1'b0), ExpFips);
        check("model_fixed", model(VecFixed, 1'b0), ExpFixed);
        check("model_bypass", model(VecByp, 1'b1), VecByp);

        #22 rst_n = 1'b1;

        run_block(0, VecSingle, 1'b0, 5, ExpSingle, "single_c1");
        run_block(0, VecFips,   1'b0, 5, ExpFips,   "fips_c1");
        run_block(1, VecFips,   1'b0, 3, ExpFips,   "fips_c2");
        run_block(2, VecFips,   1'b0, 2, ExpFips,   "fips_c4");
        run_block(2, VecFixed,  1'b0, 2, ExpFixed,  "fixed_c4");
        run_block(0, VecByp,    1'b1, 1, VecByp,    "bypass_c1");
        run_block(2, VecByp,    1'b1, 1, VecByp,    "bypass_c4");

        // Backpressure: result must hold while upstream pokes in_valid.
        out_ready[1] = 1'b0;
        run_block(1, VecFips, 1'b0, 3, ExpFips, "bp_c2");
        for (int i = 0; i < 10; i++) begin
            in_valid[1] = 1'b1;
            in_state    = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #2;
            check("bp_out_valid", 128'(out_valid[1]), 128'd1);
            check("bp_in_ready", 128'(in_ready[1]), 128'd0);
            check("bp_out_state", out_state[1], ExpFips);
        end
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b1;
        @(posedge clk); #2;
        check("bp_release_out_valid", 128'(out_valid[1]), 128'd0);
        check("bp_release_in_ready", 128'(in_ready[1]), 128'd1);
        run_block(1, VecFixed, 1'b0, 3, ExpFixed, "after_bp_c2");

        // Async reset after the second BUSY cycle.
        @(posedge clk); #2;
        in_state    = VecFips;
        in_bypass   = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk); #2;
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 128'(out_valid[0]), 128'd0);
        check("async_rst_in_ready", 128'(in_ready[0]), 128'd1);
        check("async_rst_out_state", out_state[0], 128'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_block(0, VecFips, 1'b0, 5, ExpFips, "post_rst_fips_c1");

        repeat (3) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
